// File: rtl/npc_pkg.sv
// npc_pkg: definitions shared across the NPC core.
//   - RV32I opcode constants
//   - ALU operation enum, as seen by the execute unit
//   - immediate format select used by imm_gen
//   - decode-stage handshake states
//   - NOP / EBREAK instruction words
//   - helper that maps funct3 (plus the inst[30] "alt" bit) to an ALU op
package npc_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INST    = 32'h00000013;
    localparam logic [31:0] EBREAK_INST = 32'h00100073;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_COPY_B = 4'd10
    } alu_op_e;

    // IMM_Z yields a zero immediate (R-type and anything without one)
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } imm_fmt_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } idu_state_e;

    // alt = inst[30]; only meaningful for funct3 000 (SUB) and 101 (SRA).
    // Callers decide whether alt may select SUB (OP) or not (OP-IMM).
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3,
                                                input logic       alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate generator.
//   inst  in  32  instruction word
//   fmt   in  3   immediate format (imm_fmt_e)
//   imm   out 32  immediate, sign-extended from inst[31]
module imm_gen
    import npc_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [2:0]  fmt,
    output logic [31:0] imm
);

    // Opcode bits never contribute to an immediate
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    always_comb begin
        imm = '0;
        case (imm_fmt_e'(fmt))
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                            inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                            inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/idu_stage.sv
// idu_stage: instruction-decode stage of the NPC multi-cycle core.
// Accepts one instruction from fetch, decodes it into registered fields and
// holds the bundle until execute takes it. One instruction in flight at a time.
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     fetch handshake; in_inst, in_pc carried with it
//   out_valid/out_ready   execute handshake
//   out_pc                PC of the held instruction
//   out_rs1/rs2/rd        raw register fields inst[19:15]/[24:20]/[11:7]
//   out_imm               sign-extended immediate
//   out_alu_op            alu_op_e code
//   out_alu_src_a/b       operand selects (a: 0=rs1 1=pc, b: 0=rs2 1=imm)
//   out_reg_wen           write-back enable, never set for rd==x0
//   out_mem_ren/wen       load / store
//   out_mem_size          funct3 for load/store/branch
//   out_branch/jal/jalr   control transfer
//   out_ebreak            ebreak
//   out_illegal           unrecognised encoding (all enables cleared)
module idu_stage
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_INST = 32'h00000013,
    parameter logic [31:0] RESET_PC   = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic [3:0]  out_alu_op,
    output logic        out_alu_src_a,
    output logic        out_alu_src_b,
    output logic        out_reg_wen,
    output logic        out_mem_ren,
    output logic        out_mem_wen,
    output logic [2:0]  out_mem_size,
    output logic        out_branch,
    output logic        out_jal,
    output logic        out_jalr,
    output logic        out_ebreak,
    output logic        out_illegal
);

    idu_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_HOLD;
            end
            default: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
        endcase
    end

    // Reset reuses the decoder: the output registers load the decode of
    // RESET_INST/RESET_PC, so reset values always match the parameters.
    logic        load;
    logic [31:0] cap_inst, cap_pc;

    assign load     = rst | ((state_q == ST_IDLE) & in_valid);
    assign cap_inst = rst ? RESET_INST : in_inst;
    assign cap_pc   = rst ? RESET_PC   : in_pc;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = cap_inst[6:0];
    assign funct3 = cap_inst[14:12];
    assign funct7 = cap_inst[31:25];

    imm_fmt_e    dec_fmt;
    alu_op_e     dec_alu_op;
    logic        dec_src_a, dec_src_b, dec_reg_wen, dec_mem_ren, dec_mem_wen;
    logic [2:0]  dec_mem_size;
    logic        dec_branch, dec_jal, dec_jalr, dec_ebreak, dec_illegal;
    logic [31:0] dec_imm;

    always_comb begin
        dec_fmt      = IMM_Z;
        dec_alu_op   = ALU_ADD;
        dec_src_a    = 1'b0;
        dec_src_b    = 1'b0;
        dec_reg_wen  = 1'b0;
        dec_mem_ren  = 1'b0;
        dec_mem_wen  = 1'b0;
        dec_mem_size = 3'b000;
        dec_branch   = 1'b0;
        dec_jal      = 1'b0;
        dec_jalr     = 1'b0;
        dec_ebreak   = 1'b0;
        dec_illegal  = 1'b0;

        case (opcode)
            OPC_LUI: begin
                dec_fmt     = IMM_U;
                dec_alu_op  = ALU_COPY_B;
                dec_src_b   = 1'b1;
                dec_reg_wen = 1'b1;
            end
            OPC_AUIPC: begin
                dec_fmt     = IMM_U;
                dec_src_a   = 1'b1;
                dec_src_b   = 1'b1;
                dec_reg_wen = 1'b1;
            end
            // ALU computes the jump target; EXU forms the link value pc+4
            OPC_JAL: begin
                dec_fmt     = IMM_J;
                dec_src_a   = 1'b1;
                dec_src_b   = 1'b1;
                dec_jal     = 1'b1;
                dec_reg_wen = 1'b1;
            end
            OPC_JALR: begin
                dec_fmt     = IMM_I;
                dec_src_b   = 1'b1;
                dec_jalr    = 1'b1;
                dec_reg_wen = 1'b1;
            end
            // ALU compares rs1-rs2; funct3 rides on mem_size for the condition
            OPC_BRANCH: begin
                dec_fmt      = IMM_B;
                dec_alu_op   = ALU_SUB;
                dec_branch   = 1'b1;
                dec_mem_size = funct3;
                dec_illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                dec_fmt      = IMM_I;
                dec_src_b    = 1'b1;
                dec_mem_ren  = 1'b1;
                dec_reg_wen  = 1'b1;
                dec_mem_size = funct3;
                dec_illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                               (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec_fmt      = IMM_S;
                dec_src_b    = 1'b1;
                dec_mem_wen  = 1'b1;
                dec_mem_size = funct3;
                dec_illegal  = (funct3 > 3'b010);
            end
            // inst[30] only picks SRAI over SRLI; there is no SUBI
            OPC_OP_IMM: begin
                dec_fmt     = IMM_I;
                dec_src_b   = 1'b1;
                dec_reg_wen = 1'b1;
                dec_alu_op  = alu_from_funct3(funct3,
                                              (funct3 == 3'b101) & cap_inst[30]);
            end
            OPC_OP: begin
                dec_reg_wen = 1'b1;
                dec_alu_op  = alu_from_funct3(funct3, cap_inst[30]);
                dec_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OPC_SYSTEM: begin
                dec_fmt     = IMM_I;
                dec_ebreak  = (cap_inst == EBREAK_INST);
                dec_illegal = (cap_inst != EBREAK_INST);
            end
            default: dec_illegal = 1'b1;
        endcase

        // An illegal word must not trigger any side effect downstream
        if (dec_illegal) begin
            dec_reg_wen = 1'b0;
            dec_mem_ren = 1'b0;
            dec_mem_wen = 1'b0;
            dec_branch  = 1'b0;
            dec_jal     = 1'b0;
            dec_jalr    = 1'b0;
            dec_ebreak  = 1'b0;
        end

        // x0 is hardwired; suppressing the write here keeps EXU/WB simpler
        if (cap_inst[11:7] == 5'd0) dec_reg_wen = 1'b0;
    end

    imm_gen u_imm_gen (
        .inst (cap_inst),
        .fmt  (dec_fmt),
        .imm  (dec_imm)
    );

    // Decoded bundle registers: loaded on acceptance (or reset), frozen in HOLD
    always_ff @(posedge clk) begin
        if (load) begin
            out_pc        <= cap_pc;
            out_rs1       <= cap_inst[19:15];
            out_rs2       <= cap_inst[24:20];
            out_rd        <= cap_inst[11:7];
            out_imm       <= dec_imm;
            out_alu_op    <= dec_alu_op;
            out_alu_src_a <= dec_src_a;
            out_alu_src_b <= dec_src_b;
            out_reg_wen   <= dec_reg_wen;
            out_mem_ren   <= dec_mem_ren;
            out_mem_wen   <= dec_mem_wen;
            out_mem_size  <= dec_mem_size;
            out_branch    <= dec_branch;
            out_jal       <= dec_jal;
            out_jalr      <= dec_jalr;
            out_ebreak    <= dec_ebreak;
            out_illegal   <= dec_illegal;
        end
    end

endmodule
